fb_read_arbiter: RTL and testbench
==================================

# fb_read_arbiter

Single-clock arbiter that shares the frame buffer's one read port between three requesters: the VGA display scanner, the image-processing engine and the UART frame-dump path. The display has strict priority and is never stalled. Processing and dump share the remaining slots round-robin through valid/ready handshakes. The block drives the buffer read address, tracks each in-flight read through the buffer's fixed read latency, and steers returned pixels to their owner.

## Interface

**Parameters**
- ADDR_W, 19, pixel address width
- DATA_W, 8, pixel width
- NUM_PIX, 307200, valid addresses 0..NUM_PIX-1 (640x480)
- RD_LAT, 1, buffer read latency in cycles, legal range 1..3

**Ports**
- clk  in  1  single clock for all logic; reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- disp_req  in  1  display read request; always granted
- disp_addr  in  ADDR_W  display pixel address
- disp_rdata  out  DATA_W  display pixel
- disp_rvalid  out  1  disp_rdata valid strobe
- proc_valid  in  1  processing request
- proc_addr  in  ADDR_W  processing address
- proc_ready  out  1  processing request accepted this cycle
- proc_rdata  out  DATA_W  processing pixel
- proc_rvalid  out  1  proc_rdata valid strobe
- dump_valid  in  1  dump request
- dump_addr  in  ADDR_W  dump address
- dump_ready  out  1  dump request accepted this cycle
- dump_rdata  out  DATA_W  dump pixel
- dump_rvalid  out  1  dump_rdata valid strobe
- buf_addr_rd  out  ADDR_W  registered read address to the frame buffer
- buf_rdata  in  DATA_W  frame buffer read data
- err_oob  out  1  sticky flag: an out-of-range address was accepted
- err_clr  in  1  clears err_oob

## Operation

**Grant per cycle**
- If disp_req=1, the display is granted.
- Otherwise, the round-robin winner among proc_valid and dump_valid is granted.
- If neither requests, no grant is made.

**Round-robin pointer**
- rr_ptr is one bit, 0 = processing preferred.
- When both valid requests are present, the preferred requester wins.
- After any proc or dump grant, rr_ptr points to the other requester.
- When only one valid request is present, it wins and rr_ptr still flips.
- Display grants leave rr_ptr unchanged.

**Ready outputs**
- proc_ready and dump_ready are combinational from disp_req, both valids and rr_ptr.
- At most one ready is high per cycle.
- Ready never depends on its own valid being high, except that ready=0 whenever valid=0.
- Handshake = valid & ready. A requester holds its valid and address stable until the handshake.

**Issuing a read**
- On a grant, the granted address is registered into buf_addr_rd.
- A tag {owner, oob} enters the tag pipeline.
- With no grant, buf_addr_rd holds its value and the pipeline inserts TAG_NONE.

**Out-of-range requests (address >= NUM_PIX)**
- The request is still granted and its tag carries oob=1.
- buf_addr_rd is loaded with 0.
- The owner receives rdata=0 with a normal rvalid.
- err_oob is set when the request is accepted.

**err_oob behaviour**
- err_clr clears err_oob.
- If a set and err_clr occur in the same cycle, the set wins.

**Return path**
- When a tag exits the pipeline, the owner's rvalid pulses for one cycle.
- The owner's rdata = buf_rdata, or 0 if oob.
- Non-owner rdata outputs hold their previous value.

**Reset**
- Clears rr_ptr, err_oob, buf_addr_rd and all rdata/rvalid outputs to 0.
- Flushes the tag pipeline to TAG_NONE, so reads in flight at reset never produce rvalid.

## Timing

- Throughput: one grant per cycle, with back-to-back grants to any mix of requesters.
- Latency: request granted in cycle N → buf_addr_rd valid in N+1 → owner rvalid/rdata valid in cycle N+1+RD_LAT (N+2 for RD_LAT=1).
- Tag pipeline depth is RD_LAT+1 stages. Returns come back in grant order with no reordering.
- The display sees a constant latency, so the scanner can pre-fetch exactly RD_LAT+1 pixels ahead.
- Sustained disp_req=1 starves proc and dump indefinitely, by design. The scanner releases the port during blanking.
- All rvalid outputs are 0 in the first cycle after rst_n rises, and stay 0 until a grant has propagated.

## Structure

- Package fb_arb_pkg holds:
  - NUM_PIX, ADDR_W, DATA_W constants
  - tag owner typedef: TAG_NONE, TAG_DISP, TAG_PROC, TAG_DUMP
  - tag struct {owner, oob}
- Sub-module fb_rd_tag_pipe: a parameterised (RD_LAT+1)-deep tag shift register with synchronous active-low clear. It is instantiated once.
- The top level contains the grant logic, rr_ptr, address register, err_oob and the return demux.

## Test plan

- **Reset and idle:** hold rst_n=0 for 3 cycles, then release with no requests → all outputs 0 and no rvalid for 20 cycles.
- **Display priority:** disp_req=1 with addr 100 while proc_valid=1 with addr 200 → proc_ready=0. disp_rvalid at +2 carries mem[100]. Drop disp_req → proc granted and proc_rvalid at +2 carries mem[200].
- **Round-robin:** proc_valid and dump_valid both held for 4 cycles → grants alternate P,D,P,D starting from P after reset. Returns arrive in the same order with correct data.
- **Out of range:** proc_addr=307200 → proc_rvalid with rdata=0, err_oob=1. Pulse err_clr alongside a second OOB accept → err_oob stays 1. Pulse err_clr alone → err_oob=0.
- **Reset mid-flight:** grant a dump read at addr 5, then assert rst_n=0 in the next cycle → dump_rvalid never pulses.
- **Latency sweep:** run RD_LAT=1,2,3 with streamed display addresses 0..639 → disp_rvalid trails each request by RD_LAT+1 cycles and data matches the buffer model.

Source files
------------

// File: rtl/fb_read_arbiter_pkg.sv
// Shared types and constants for the frame-buffer read arbiter: geometry
// constants, the read-tag owner encoding and the tag carried through the read latency.
package fb_arb_pkg;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
    localparam int NUM_PIX = 307200;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_PROC = 2'd2,
        TAG_DUMP = 2'd3
    } tag_owner_e;

    typedef struct packed {
        tag_owner_e owner;
        logic       oob;
    } rd_tag_t;

    localparam rd_tag_t TAG_IDLE = '{owner: TAG_NONE, oob: 1'b0};

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Requester, frame-buffer and error signals of the read arbiter, grouped as one bundle.
// The slave modport is the arbiter side; master is the requester/buffer side.
interface fb_read_arbiter_if #(
    parameter int ADDR_W = fb_arb_pkg::ADDR_W,
    parameter int DATA_W = fb_arb_pkg::DATA_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    logic              proc_valid;
    logic [ADDR_W-1:0] proc_addr;
    logic              proc_ready;
    logic [DATA_W-1:0] proc_rdata;
    logic              proc_rvalid;

    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_rdata;
    logic              dump_rvalid;

    logic [ADDR_W-1:0] buf_addr_rd;
    logic [DATA_W-1:0] buf_rdata;

    logic              err_oob;
    logic              err_clr;

    modport slave (
        input  disp_req, disp_addr, proc_valid, proc_addr, dump_valid, dump_addr,
               buf_rdata, err_clr,
        output disp_rdata, disp_rvalid, proc_ready, proc_rdata, proc_rvalid,
               dump_ready, dump_rdata, dump_rvalid, buf_addr_rd, err_oob
    );

    modport master (
        output disp_req, disp_addr, proc_valid, proc_addr, dump_valid, dump_addr,
               buf_rdata, err_clr,
        input  disp_rdata, disp_rvalid, proc_ready, proc_rdata, proc_rvalid,
               dump_ready, dump_rdata, dump_rvalid, buf_addr_rd, err_oob
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Fixed-depth shift register carrying each read's {owner, oob} tag alongside
// the frame buffer's read latency; synchronous active-low clear flushes to TAG_NONE.
module fb_rd_tag_pipe
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];

    // NOTE: every stage is cleared, not just a valid bit -- a read in flight at
    // reset must never surface as an rvalid. This is a handful of flops, not a RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Shares the frame buffer read port: display has strict priority, processing and
// dump alternate round-robin. Returned pixels are steered to their owner by tag.
module fb_read_arbiter #(
    parameter int ADDR_W  = fb_arb_pkg::ADDR_W,
    parameter int DATA_W  = fb_arb_pkg::DATA_W,
    parameter int NUM_PIX = fb_arb_pkg::NUM_PIX,
    parameter int RD_LAT  = 1
) (
    input logic              clk,
    input logic              rst_n,
    fb_read_arbiter_if.slave bus
);
    import fb_arb_pkg::*;

    // One extra bit so NUM_PIX == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(NUM_PIX);

    tag_owner_e        gnt_owner;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oob;
    logic              proc_ready;
    logic              dump_ready;
    logic              rr_ptr;
    logic [ADDR_W-1:0] buf_addr_q;
    logic              err_oob_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    // NOTE: all outputs get a default before any branch, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        gnt_owner  = TAG_NONE;
        gnt_addr   = '0;
        proc_ready = 1'b0;
        dump_ready = 1'b0;
        if (rst_n) begin
            if (bus.disp_req) begin
                gnt_owner = TAG_DISP;
                gnt_addr  = bus.disp_addr;
            end else if (bus.proc_valid && (!rr_ptr || !bus.dump_valid)) begin
                gnt_owner  = TAG_PROC;
                gnt_addr   = bus.proc_addr;
                proc_ready = 1'b1;
            end else if (bus.dump_valid) begin
                gnt_owner  = TAG_DUMP;
                gnt_addr   = bus.dump_addr;
                dump_ready = 1'b1;
            end
        end
    end

    assign gnt_oob = (gnt_owner != TAG_NONE) && ({1'b0, gnt_addr} >= PIX_LIMIT);
    assign tag_in  = '{owner: gnt_owner, oob: gnt_oob};

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            buf_addr_q <= '0;
            err_oob_q  <= 1'b0;
        end else begin
            if (gnt_owner != TAG_NONE) begin
                buf_addr_q <= gnt_oob ? '0 : gnt_addr;
            end
            if (proc_ready) begin
                rr_ptr <= 1'b1;
            end else if (dump_ready) begin
                rr_ptr <= 1'b0;
            end
            // A new error outranks a clear in the same cycle.
            if (gnt_oob) begin
                err_oob_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_oob_q <= 1'b0;
            end
        end
    end

    fb_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    logic [DATA_W-1:0] ret_data;
    logic              disp_hit;
    logic              proc_hit;
    logic              dump_hit;
    logic [DATA_W-1:0] disp_hold;
    logic [DATA_W-1:0] proc_hold;
    logic [DATA_W-1:0] dump_hold;

    assign ret_data = tag_out.oob ? '0 : bus.buf_rdata;
    assign disp_hit = rst_n && (tag_out.owner == TAG_DISP);
    assign proc_hit = rst_n && (tag_out.owner == TAG_PROC);
    assign dump_hit = rst_n && (tag_out.owner == TAG_DUMP);

    // Each owner keeps its last pixel until its next return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_hold <= '0;
            proc_hold <= '0;
            dump_hold <= '0;
        end else begin
            if (disp_hit) disp_hold <= ret_data;
            if (proc_hit) proc_hold <= ret_data;
            if (dump_hit) dump_hold <= ret_data;
        end
    end

    assign bus.disp_rvalid = disp_hit;
    assign bus.proc_rvalid = proc_hit;
    assign bus.dump_rvalid = dump_hit;
    assign bus.disp_rdata  = disp_hit ? ret_data : disp_hold;
    assign bus.proc_rdata  = proc_hit ? ret_data : proc_hold;
    assign bus.dump_rdata  = dump_hit ? ret_data : dump_hold;
    assign bus.proc_ready  = proc_ready;
    assign bus.dump_ready  = dump_ready;
    assign bus.buf_addr_rd = buf_addr_q;
    assign bus.err_oob     = err_oob_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: three instances at RD_LAT=1,2,3 share the
// same stimulus, each with its own frame-buffer model of matching latency.
module tb_fb_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        proc_valid;
    logic [18:0] proc_addr;
    logic        dump_valid;
    logic [18:0] dump_addr;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    logic [2:0]       disp_rvalid_a, proc_rvalid_a, dump_rvalid_a;
    logic [2:0]       proc_ready_a, dump_ready_a, err_oob_a;
    logic [2:0][7:0]  disp_rdata_a, proc_rdata_a, dump_rdata_a;
    logic [2:0][18:0] buf_addr_a;

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = g + 1;
        fb_read_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();
        logic [7:0] rd_pipe [L];

        assign bus.disp_req   = disp_req;
        assign bus.disp_addr  = disp_addr;
        assign bus.proc_valid = proc_valid;
        assign bus.proc_addr  = proc_addr;
        assign bus.dump_valid = dump_valid;
        assign bus.dump_addr  = dump_addr;
        assign bus.err_clr    = err_clr;

        always @(posedge clk) begin
            rd_pipe[0] <= pix(bus.buf_addr_rd);
            for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign bus.buf_rdata = rd_pipe[L-1];

        fb_read_arbiter #(
            .ADDR_W  (19),
            .DATA_W  (8),
            .NUM_PIX (307200),
            .RD_LAT  (L)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign disp_rvalid_a[g] = bus.disp_rvalid;
        assign proc_rvalid_a[g] = bus.proc_rvalid;
        assign dump_rvalid_a[g] = bus.dump_rvalid;
        assign proc_ready_a[g]  = bus.proc_ready;
        assign dump_ready_a[g]  = bus.dump_ready;
        assign err_oob_a[g]     = bus.err_oob;
        assign disp_rdata_a[g]  = bus.disp_rdata;
        assign proc_rdata_a[g]  = bus.proc_rdata;
        assign dump_rdata_a[g]  = bus.dump_rdata;
        assign buf_addr_a[g]    = bus.buf_addr_rd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        disp_req   = 1'b0;
        disp_addr  = '0;
        proc_valid = 1'b0;
        proc_addr  = '0;
        dump_valid = 1'b0;
        dump_addr  = '0;
        err_clr    = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sample();
        check("rst_rvalid", {disp_rvalid_a, proc_rvalid_a, dump_rvalid_a}, 32'd0);
        check("rst_ready", {proc_ready_a, dump_ready_a}, 32'd0);
        check("rst_err", err_oob_a, 32'd0);
        check("rst_buf_addr", buf_addr_a[0], 32'd0);
        check("rst_rdata", {disp_rdata_a[0], proc_rdata_a[0], dump_rdata_a[0]}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            sample();
            check("idle_rvalid", {disp_rvalid_a, proc_rvalid_a, dump_rvalid_a}, 32'd0);
        end

        // Round-robin, starting with processing after reset
        next_cycle();
        proc_valid = 1'b1; proc_addr = 19'd10;
        dump_valid = 1'b1; dump_addr = 19'd20;
        sample();
        check("rr0_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b10);
        next_cycle();
        proc_addr = 19'd11;
        sample();
        check("rr1_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b01);
        next_cycle();
        dump_addr = 19'd21;
        sample();
        check("rr2_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b10);
        check("rr2_proc_rvalid", proc_rvalid_a[0], 32'd1);
        check("rr2_proc_rdata", proc_rdata_a[0], 32'hAF);
        next_cycle();
        proc_addr = 19'd12;
        sample();
        check("rr3_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b01);
        check("rr3_dump_rvalid", dump_rvalid_a[0], 32'd1);
        check("rr3_dump_rdata", dump_rdata_a[0], 32'hB1);
        next_cycle();
        dump_valid = 1'b0;
        sample();
        check("rr4_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b10);
        check("rr4_proc_rdata", {7'd0, proc_rvalid_a[0], proc_rdata_a[0]}, 32'h1AE);
        next_cycle();
        proc_valid = 1'b0;
        sample();
        check("rr5_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b00);
        check("rr5_dump_rdata", {7'd0, dump_rvalid_a[0], dump_rdata_a[0]}, 32'h1B0);
        check("rr5_proc_rvalid", proc_rvalid_a[0], 32'd0);
        next_cycle();
        sample();
        check("rr6_proc_rdata", {7'd0, proc_rvalid_a[0], proc_rdata_a[0]}, 32'h1A9);
        next_cycle();
        sample();
        check("rr7_rvalid", {disp_rvalid_a[0], proc_rvalid_a[0], dump_rvalid_a[0]}, 32'd0);
        check("rr7_dump_hold", dump_rdata_a[0], 32'hB0);

        // Display priority
        next_cycle();
        disp_req = 1'b1; disp_addr = 19'd100;
        proc_valid = 1'b1; proc_addr = 19'd200;
        sample();
        check("dp0_ready", {proc_ready_a[0], dump_ready_a[0]}, 32'b00);
        next_cycle();
        disp_req = 1'b0;
        sample();
        check("dp1_proc_ready", proc_ready_a[0], 32'd1);
        check("dp1_buf_addr", buf_addr_a[0], 32'd100);
        next_cycle();
        proc_valid = 1'b0;
        sample();
        check("dp2_disp_rdata", {7'd0, disp_rvalid_a[0], disp_rdata_a[0]}, 32'h1C1);
        check("dp2_proc_rvalid", proc_rvalid_a[0], 32'd0);
        check("dp2_buf_addr", buf_addr_a[0], 32'd200);
        next_cycle();
        sample();
        check("dp3_proc_rdata", {7'd0, proc_rvalid_a[0], proc_rdata_a[0]}, 32'h16D);
        check("dp3_disp_hold", {7'd0, disp_rvalid_a[0], disp_rdata_a[0]}, 32'h0C1);
        check("dp3_disp_lat2", {7'd0, disp_rvalid_a[1], disp_rdata_a[1]}, 32'h1C1);

        // Out-of-range accesses and err_oob
        next_cycle();
        proc_valid = 1'b1; proc_addr = 19'd307200;
        sample();
        check("oob0_ready", proc_ready_a[0], 32'd1);
        check("oob0_err", err_oob_a[0], 32'd0);
        next_cycle();
        proc_valid = 1'b0;
        sample();
        check("oob1_buf_addr", buf_addr_a[0], 32'd0);
        check("oob1_err", err_oob_a[0], 32'd1);
        next_cycle();
        sample();
        check("oob2_proc_rdata", {7'd0, proc_rvalid_a[0], proc_rdata_a[0]}, 32'h100);
        next_cycle();
        err_clr = 1'b1;
        dump_valid = 1'b1; dump_addr = 19'd400000;
        sample();
        check("oob3_dump_ready", dump_ready_a[0], 32'd1);
        next_cycle();
        err_clr = 1'b0;
        dump_valid = 1'b0;
        sample();
        check("oob4_set_wins", err_oob_a[0], 32'd1);
        next_cycle();
        err_clr = 1'b1;
        sample();
        check("oob5_dump_rdata", {7'd0, dump_rvalid_a[0], dump_rdata_a[0]}, 32'h100);
        next_cycle();
        err_clr = 1'b0;
        sample();
        check("oob6_err_cleared", err_oob_a[0], 32'd0);

        // Reset with a dump read in flight
        next_cycle();
        dump_valid = 1'b1; dump_addr = 19'd5;
        sample();
        check("mf0_dump_ready", dump_ready_a[0], 32'd1);
        next_cycle();
        dump_valid = 1'b0;
        rst_n = 1'b0;
        sample();
        check("mf1_dump_rvalid", dump_rvalid_a, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("mf2_dump_rvalid", dump_rvalid_a, 32'd0);
        check("mf2_buf_addr", buf_addr_a[0], 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("mf_tail_rvalid", {disp_rvalid_a, proc_rvalid_a, dump_rvalid_a}, 32'd0);
        end

        // Latency sweep: streamed display line on all three latencies
        for (int c = 0; c < 644; c++) begin
            next_cycle();
            disp_req  = (c < 640);
            disp_addr = (c < 640) ? 19'(c) : 19'd0;
            sample();
            for (int g = 0; g < 3; g++) begin
                int  k;
                logic exp_v;
                k     = c - (g + 2);
                exp_v = (k >= 0) && (k < 640);
                check("sweep_rvalid", disp_rvalid_a[g], {31'd0, exp_v});
                if (exp_v) begin
                    check("sweep_rdata", disp_rdata_a[g], {24'd0, pix(19'(k))});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
